// File: rtl/acl_display_refresh_scheduler_if.sv
// Display-driver link: one 16-char ASCII line per valid/ready beat.
// master drives line data/number/valid, slave returns ready.
interface acl_display_refresh_scheduler_if;
  logic [127:0] o_line_dat;
  logic         o_line_num;
  logic         o_line_valid;
  logic         i_line_ready;

  modport master (
    output o_line_dat,
    output o_line_num,
    output o_line_valid,
    input  i_line_ready
  );

  modport slave (
    input  o_line_dat,
    input  o_line_num,
    input  o_line_valid,
    output i_line_ready
  );
endinterface

// File: rtl/acl_display_refresh_scheduler.sv
// Periodically snapshots the latest ADXL362 reading and sends a line pair to
// the display. Ports: clk/rst, reading strobe+data, mode, converter lines, disp.
module acl_display_refresh_scheduler #(
  parameter int PARAM_REFRESH_CYCLES = 2000000,
  parameter int PARAM_STALE_CYCLES   = 20000000
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic         i_reading_valid,
  input  logic [63:0]  i_3axis_temp,
  input  logic         i_mode_txt,
  output logic [63:0]  o_3axis_temp,
  output logic         o_reading_inactive,
  input  logic [127:0] i_dat_ascii_line1,
  input  logic [127:0] i_dat_ascii_line2,
  input  logic [127:0] i_txt_ascii_line1,
  input  logic [127:0] i_txt_ascii_line2,
  output logic         o_busy,
  acl_display_refresh_scheduler_if.master disp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LATCH   = 2'd1;
  localparam logic [1:0] SEND_L1 = 2'd2;
  localparam logic [1:0] SEND_L2 = 2'd3;

  localparam logic [23:0] REF_LAST =
    24'(PARAM_REFRESH_CYCLES - 1);
  localparam logic [24:0] STALE_MAX =
    25'(PARAM_STALE_CYCLES);

  logic [1:0]   state_q, state_d;
  logic [23:0]  ref_q;
  logic [24:0]  stale_q;
  logic         nrd_q;
  logic [63:0]  shadow_q;
  logic         pend_q, pend_d;
  logic [63:0]  temp_q, temp_d;
  logic         inact_q, inact_d;
  logic         mode_q, mode_d;
  logic [127:0] dat_q, dat_d;
  logic [127:0] l2_q, l2_d;
  logic         num_q, num_d;
  logic         valid_q, valid_d;

  logic tick, live_inact, enter_latch;

  assign tick       = (ref_q == REF_LAST);
  assign live_inact = nrd_q | (stale_q == STALE_MAX);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    temp_d      = temp_q;
    inact_d     = inact_q;
    mode_d      = mode_q;
    dat_d       = dat_q;
    l2_d        = l2_q;
    num_d       = num_q;
    valid_d     = valid_q;
    enter_latch = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d     = LATCH;
          enter_latch = 1'b1;
        end
      end
      LATCH: begin
        state_d = SEND_L1;
        dat_d   = mode_q ? i_txt_ascii_line1
                         : i_dat_ascii_line1;
        l2_d    = mode_q ? i_txt_ascii_line2
                         : i_dat_ascii_line2;
        num_d   = 1'b0;
        valid_d = 1'b1;
      end
      SEND_L1: begin
        if (disp.i_line_ready) begin
          state_d = SEND_L2;
          dat_d   = l2_q;
          num_d   = 1'b1;
        end
      end
      SEND_L2: begin
        if (disp.i_line_ready) begin
          valid_d = 1'b0;
          if (pend_q) begin
            state_d     = LATCH;
            enter_latch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A strobe on the latch edge bypasses the shadow so the freshest
    // reading is shown and it cannot be stale.
    if (enter_latch) begin
      temp_d  = i_reading_valid ? i_3axis_temp : shadow_q;
      inact_d = i_reading_valid ? 1'b0 : live_inact;
      mode_d  = i_mode_txt;
      pend_d  = 1'b0;
    end else if (tick && state_q != IDLE) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      stale_q  <= '0;
      nrd_q    <= 1'b1;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      temp_q   <= '0;
      inact_q  <= 1'b1;
      mode_q   <= 1'b0;
      dat_q    <= '0;
      l2_q     <= '0;
      num_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q   <= tick ? '0 : ref_q + 24'd1;
      if (i_reading_valid) begin
        shadow_q <= i_3axis_temp;
        stale_q  <= '0;
        nrd_q    <= 1'b0;
      end else if (stale_q != STALE_MAX) begin
        stale_q <= stale_q + 25'd1;
      end
      pend_q  <= pend_d;
      temp_q  <= temp_d;
      inact_q <= inact_d;
      mode_q  <= mode_d;
      dat_q   <= dat_d;
      l2_q    <= l2_d;
      num_q   <= num_d;
      valid_q <= valid_d;
    end
  end

  assign o_3axis_temp       = temp_q;
  assign o_reading_inactive = inact_q;
  assign o_busy             = (state_q != IDLE);
  assign disp.o_line_dat    = dat_q;
  assign disp.o_line_num    = num_q;
  assign disp.o_line_valid  = valid_q;

endmodule

// File: tb/tb_acl_display_refresh_scheduler.sv
// Directed bench for the display refresh scheduler with a behavioural
// ASCII converter; refresh period 16, stale limit 64.
module tb_acl_display_refresh_scheduler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rd_valid = 1'b0;
  logic [63:0]  rd_data = '0;
  logic         mode = 1'b0;
  logic [63:0]  snap;
  logic         inact;
  logic [127:0] dl1, dl2, tl1, tl2;
  logic         busy;
  int           total = 0;
  int           passed = 0;

  acl_display_refresh_scheduler_if dif ();

  acl_display_refresh_scheduler #(
    .PARAM_REFRESH_CYCLES(16),
    .PARAM_STALE_CYCLES(64)
  ) dut (
    .i_clk_20mhz       (clk),
    .i_rst_20mhz       (rst),
    .i_reading_valid   (rd_valid),
    .i_3axis_temp      (rd_data),
    .i_mode_txt        (mode),
    .o_3axis_temp      (snap),
    .o_reading_inactive(inact),
    .i_dat_ascii_line1 (dl1),
    .i_dat_ascii_line2 (dl2),
    .i_txt_ascii_line1 (tl1),
    .i_txt_ascii_line2 (tl2),
    .o_busy            (busy),
    .disp              (dif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  function automatic logic [31:0] h16(input logic [15:0] v);
    return {hc(v[15:12]), hc(v[11:8]), hc(v[7:4]), hc(v[3:0])};
  endfunction

  always_comb begin
    dl1 = "X:____  Y:____  ";
    dl2 = "Z:____  T:____  ";
    if (!inact) begin
      dl1 = {"X:", h16({snap[55:48], snap[63:56]}),
             "  Y:", h16({snap[39:32], snap[47:40]}), "  "};
      dl2 = {"Z:", h16({snap[23:16], snap[31:24]}),
             "  T:", h16({snap[7:0], snap[15:8]}), "  "};
    end
    tl1 = "TXT LINE ONE    ";
    tl2 = "TXT LINE TWO    ";
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (dif.o_line_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(dif.o_line_valid), 128'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(busy), 128'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_valid"}, 128'(dif.o_line_valid), 128'd0);
    chk({tag, "_num"},   128'(dif.o_line_num), 128'd0);
    chk({tag, "_dat"},   dif.o_line_dat, 128'd0);
    chk({tag, "_temp"},  128'(snap), 128'd0);
    chk({tag, "_inact"}, 128'(inact), 128'd1);
    chk({tag, "_busy"},  128'(busy), 128'd0);
  endtask

  localparam logic [63:0] RA = 64'h9C01_3800_E803_1400;
  localparam logic [63:0] RB = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] RC = 64'hA5A5_0000_FFFF_0102;

  initial begin
    bit stable;
    dif.i_line_ready = 1'b1;

    // reset values, then first pair with no reading
    @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("pre_tick_idle", 128'(busy), 128'd0);
    @(negedge clk);
    chk("latch_busy", 128'(busy), 128'd1);
    chk("latch_novalid", 128'(dif.o_line_valid), 128'd0);
    @(negedge clk);
    chk("l1_valid", 128'(dif.o_line_valid), 128'd1);
    chk("l1_num", 128'(dif.o_line_num), 128'd0);
    chk("l1_inact", 128'(inact), 128'd1);
    chk("l1_dat", dif.o_line_dat, "X:____  Y:____  ");
    @(negedge clk);
    chk("l2_num", 128'(dif.o_line_num), 128'd1);
    chk("l2_dat", dif.o_line_dat, "Z:____  T:____  ");
    @(negedge clk);
    chk("end_valid", 128'(dif.o_line_valid), 128'd0);
    chk("end_busy", 128'(busy), 128'd0);

    // reading A in hex mode
    rd_valid = 1'b1;
    rd_data  = RA;
    @(negedge clk);
    rd_valid = 1'b0;
    wait_valid("a_wait", 40);
    chk("a_temp", 128'(snap), 128'(RA));
    chk("a_inact", 128'(inact), 128'd0);
    chk("a_l1", dif.o_line_dat, "X:019C  Y:0038  ");
    @(negedge clk);
    chk("a_l2", dif.o_line_dat, "Z:03E8  T:0014  ");
    @(negedge clk);
    chk("a_idle", 128'(busy), 128'd0);

    // mode captured at latch entry; later change ignored
    mode = 1'b1;
    begin
      int n = 0;
      while (busy !== 1'b1 && n < 40) begin
        @(negedge clk);
        n++;
      end
    end
    chk("m_latch", 128'(busy), 128'd1);
    mode = 1'b0;
    @(negedge clk);
    chk("m_l1", dif.o_line_dat, "TXT LINE ONE    ");
    @(negedge clk);
    chk("m_l2", dif.o_line_dat, "TXT LINE TWO    ");
    @(negedge clk);
    chk("m_idle", 128'(busy), 128'd0);

    // back-pressure across two ticks -> exactly one extra pair
    dif.i_line_ready = 1'b0;
    wait_valid("bp_wait", 40);
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dif.o_line_dat !== "X:019C  Y:0038  " ||
          dif.o_line_num !== 1'b0 ||
          dif.o_line_valid !== 1'b1)
        stable = 1'b0;
    end
    chk("bp_stable", 128'(stable), 128'd1);
    dif.i_line_ready = 1'b1;
    @(negedge clk);
    chk("bp_l2_num", 128'(dif.o_line_num), 128'd1);
    chk("bp_l2_dat", dif.o_line_dat, "Z:03E8  T:0014  ");
    @(negedge clk);
    chk("bp_relatch_busy", 128'(busy), 128'd1);
    chk("bp_relatch_valid", 128'(dif.o_line_valid), 128'd0);
    @(negedge clk);
    chk("bp_x_l1_valid", 128'(dif.o_line_valid), 128'd1);
    chk("bp_x_l1_num", 128'(dif.o_line_num), 128'd0);
    @(negedge clk);
    chk("bp_x_l2_num", 128'(dif.o_line_num), 128'd1);
    @(negedge clk);
    chk("bp_x_idle", 128'(busy), 128'd0);

    // this cycle is the tick: strobe B alongside it
    @(negedge clk);
    chk("byp_pre_idle", 128'(busy), 128'd0);
    rd_valid = 1'b1;
    rd_data  = RB;
    @(negedge clk);
    rd_valid = 1'b0;
    chk("byp_busy", 128'(busy), 128'd1);
    chk("byp_temp", 128'(snap), 128'(RB));
    chk("byp_inact", 128'(inact), 128'd0);
    @(negedge clk);
    chk("byp_l1", dif.o_line_dat, "X:3412  Y:7856  ");
    @(negedge clk);
    chk("byp_l2", dif.o_line_dat, "Z:BC9A  T:F0DE  ");

    // stale after 64 quiet clocks, cleared by the next strobe
    repeat (80) @(negedge clk);
    wait_idle("st_idle", 10);
    wait_valid("st_wait", 40);
    chk("st_inact", 128'(inact), 128'd1);
    chk("st_temp", 128'(snap), 128'(RB));
    chk("st_l1", dif.o_line_dat, "X:____  Y:____  ");
    wait_idle("st_idle2", 10);
    rd_valid = 1'b1;
    rd_data  = RC;
    @(negedge clk);
    rd_valid = 1'b0;
    wait_idle("fr_idle", 10);
    wait_valid("fr_wait", 40);
    chk("fr_inact", 128'(inact), 128'd0);
    chk("fr_temp", 128'(snap), 128'(RC));

    // reset during SEND_L2
    wait_idle("r_idle", 10);
    wait_valid("r_wait", 40);
    @(negedge clk);
    chk("r_in_l2", 128'(dif.o_line_num), 128'd1);
    rst = 1'b1;
    #1;
    chk_reset_outs("midrst");
    @(negedge clk);
    rst = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (dif.o_line_valid !== 1'b0) stable = 1'b0;
    end
    chk("rr_quiet", 128'(stable), 128'd1);
    chk("rr_latch", 128'(busy), 128'd1);
    @(negedge clk);
    chk("rr_valid", 128'(dif.o_line_valid), 128'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
